// File: rtl/stepdown_discharge_seq_if.sv
// Control bundle between the enable/UVLO logic, the output comparator and the
// step-down discharge sequencer.
//   en_req, uvlo, vout_low : asynchronous status/requests into the sequencer
//   dis_time               : discharge timeout in clock cycles
//   fault_clr              : synchronous pulse that clears a latched fault
//   conv_on                : converter run enable
//   dis_arm, dis_go        : NAND2 inputs i0 / i1 of the discharge gate drive
//   dis_done, dis_fault    : discharge completion pulse / sticky timeout flag
// The master modport is the side that drives the requests; the slave modport
// is the sequencer.
interface stepdown_discharge_seq_if #(
  parameter int DIS_W = 10
);
  logic             en_req;
  logic             uvlo;
  logic             vout_low;
  logic [DIS_W-1:0] dis_time;
  logic             fault_clr;
  logic             conv_on;
  logic             dis_arm;
  logic             dis_go;
  logic             dis_done;
  logic             dis_fault;

  modport master (
    output en_req, uvlo, vout_low, dis_time, fault_clr,
    input  conv_on, dis_arm, dis_go, dis_done, dis_fault
  );

  modport slave (
    input  en_req, uvlo, vout_low, dis_time, fault_clr,
    output conv_on, dis_arm, dis_go, dis_done, dis_fault
  );
endinterface

// File: rtl/stepdown_discharge_seq.sv
// Step-down output discharge sequencer. Drives the two inputs of the
// discharge NAND2 cell (dis_arm -> i0, dis_go -> i1); the discharge FET is on
// only while both are high. On disable or UVLO the converter is switched off,
// the cell is armed for one cycle, then Vout is discharged until the
// comparator reports low (success pulse) or the programmable timeout expires
// (sticky fault, cleared by fault_clr).
// Ports:
//   CLK            block clock, rising edge
//   RSTN           asynchronous active-low reset, synchronous release
//   CELV/CELG/SUB  supply, ground, substrate (connectivity only)
//   bus            control bundle, slave side (see stepdown_discharge_seq_if)
// Parameters:
//   DEB_CYC  consecutive synced cycles of disagreement before en_db follows
//   DIS_W    width of the discharge timeout counter and of dis_time
module stepdown_discharge_seq #(
  parameter int DEB_CYC = 8,
  parameter int DIS_W   = 10
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    CELV,
  input  logic                    CELG,
  input  logic                    SUB,
  stepdown_discharge_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_ARM,
    S_DISCH,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

  // Supply pins carry no logic; fold them into one sink net.
  logic unused_supply;
  assign unused_supply = ^{CELV, CELG, SUB};

  logic [1:0] en_sync;
  logic [1:0] uvlo_sync;
  logic [1:0] vout_sync;
  logic       en_s;
  logic       uvlo_s;
  logic       vout_s;

  logic [3:0] deb_cnt;
  logic       en_db;

  state_t           state;
  state_t           state_nxt;
  logic [DIS_W-1:0] dis_cnt;
  logic [DIS_W-1:0] dis_cnt_nxt;
  logic             vout_prev;
  logic             vout_prev_nxt;
  logic             qual;

  logic conv_on_q, dis_arm_q, dis_go_q, dis_done_q, dis_fault_q;
  logic conv_on_nxt, dis_arm_nxt, dis_go_nxt, dis_done_nxt, dis_fault_nxt;

  assign en_s   = en_sync[1];
  assign uvlo_s = uvlo_sync[1];
  assign vout_s = vout_sync[1];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      en_sync   <= '0;
      uvlo_sync <= '0;
      vout_sync <= '0;
    end else begin
      en_sync   <= {en_sync[0], bus.en_req};
      uvlo_sync <= {uvlo_sync[0], bus.uvlo};
      vout_sync <= {vout_sync[0], bus.vout_low};
    end
  end

  // en_db flips on the DEB_CYC-th consecutive disagreeing cycle; any
  // agreeing cycle restarts the run.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      deb_cnt <= '0;
      en_db   <= 1'b0;
    end else if (en_s == en_db) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      en_db   <= en_s;
    end else begin
      deb_cnt <= deb_cnt + 4'd1;
    end
  end

  // Outputs are decoded from the next state and registered together with the
  // state, so every output comes straight from a flop and the async reset
  // drops dis_go/dis_arm/conv_on without any combinational path.
  always_comb begin
    state_nxt     = state;
    dis_cnt_nxt   = '0;
    vout_prev_nxt = (state == S_DISCH) && vout_s;
    qual          = (state == S_DISCH) && vout_s && vout_prev;

    case (state)
      S_OFF:   if (en_db && !uvlo_s) state_nxt = S_ON;
      S_ON:    if (!en_db || uvlo_s) state_nxt = S_ARM;
      S_ARM:   state_nxt = S_DISCH;
      S_DISCH: begin
        // Qualification is tested first so it wins over a same-cycle timeout.
        if (qual)                         state_nxt = S_DONE;
        else if (dis_cnt == bus.dis_time) state_nxt = S_FAULT;
      end
      S_DONE:  state_nxt = S_OFF;
      S_FAULT: if (bus.fault_clr) state_nxt = S_OFF;
      default: state_nxt = S_OFF;
    endcase

    // Counter is zero in the first DISCH cycle and counts up while staying.
    if (state_nxt == S_DISCH && state == S_DISCH) dis_cnt_nxt = dis_cnt + 1'b1;

    conv_on_nxt   = (state_nxt == S_ON);
    dis_arm_nxt   = (state_nxt == S_ARM) || (state_nxt == S_DISCH);
    dis_go_nxt    = (state_nxt == S_DISCH);
    dis_done_nxt  = (state_nxt == S_DONE);
    dis_fault_nxt = (state_nxt == S_FAULT);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= S_OFF;
      dis_cnt     <= '0;
      vout_prev   <= 1'b0;
      conv_on_q   <= 1'b0;
      dis_arm_q   <= 1'b0;
      dis_go_q    <= 1'b0;
      dis_done_q  <= 1'b0;
      dis_fault_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      dis_cnt     <= dis_cnt_nxt;
      vout_prev   <= vout_prev_nxt;
      conv_on_q   <= conv_on_nxt;
      dis_arm_q   <= dis_arm_nxt;
      dis_go_q    <= dis_go_nxt;
      dis_done_q  <= dis_done_nxt;
      dis_fault_q <= dis_fault_nxt;
    end
  end

  assign bus.conv_on   = conv_on_q;
  assign bus.dis_arm   = dis_arm_q;
  assign bus.dis_go    = dis_go_q;
  assign bus.dis_done  = dis_done_q;
  assign bus.dis_fault = dis_fault_q;

endmodule

// File: tb/tb_stepdown_discharge_seq.sv
// Bench for stepdown_discharge_seq. A table of {inputs, cycle count, expected
// outputs} records is replayed in order; each cycle's expectation is queued
// when the inputs are driven and popped when the outputs are sampled 1 ns
// after the rising edge. Power-up, timing boundaries and the mid-discharge
// async reset are written out explicitly around the table.
module tb_stepdown_discharge_seq;

  localparam int DIS_W = 10;

  // Expected output vectors, bit order {conv_on, dis_arm, dis_go, dis_done, dis_fault}
  localparam logic [4:0] X_OFF  = 5'b00000;
  localparam logic [4:0] X_ON   = 5'b10000;
  localparam logic [4:0] X_ARM  = 5'b01000;
  localparam logic [4:0] X_DIS  = 5'b01100;
  localparam logic [4:0] X_DONE = 5'b00010;
  localparam logic [4:0] X_FLT  = 5'b00001;

  typedef struct {
    string            name;
    logic             en_req;
    logic             uvlo;
    logic             vout_low;
    logic             fault_clr;
    logic [DIS_W-1:0] dis_time;
    int               cycles;
    logic [4:0]       exp;
  } vec_t;

  typedef struct {
    string      name;
    int         idx;
    logic [4:0] exp;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t vecs[$];
  exp_t sb_q[$];

  stepdown_discharge_seq_if #(.DIS_W(DIS_W)) bus_if ();

  stepdown_discharge_seq #(
    .DEB_CYC(8),
    .DIS_W  (DIS_W)
  ) dut (
    .CLK (clk),
    .RSTN(rst_n),
    .CELV(1'b1),
    .CELG(1'b0),
    .SUB (1'b0),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string n, input logic e, input logic u, input logic v,
                        input logic f, input int t, input int c, input logic [4:0] x);
    vec_t r;
    r.name      = n;
    r.en_req    = e;
    r.uvlo      = u;
    r.vout_low  = v;
    r.fault_clr = f;
    r.dis_time  = DIS_W'(t);
    r.cycles    = c;
    r.exp       = x;
    vecs.push_back(r);
  endtask

  task automatic applyStimulus(input vec_t r);
    bus_if.en_req    = r.en_req;
    bus_if.uvlo      = r.uvlo;
    bus_if.vout_low  = r.vout_low;
    bus_if.fault_clr = r.fault_clr;
    bus_if.dis_time  = r.dis_time;
  endtask

  task automatic pushExp(input string n, input int i, input logic [4:0] x);
    exp_t e;
    e.name = n;
    e.idx  = i;
    e.exp  = x;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [4:0] act;
    act = {bus_if.conv_on, bus_if.dis_arm, bus_if.dis_go, bus_if.dis_done, bus_if.dis_fault};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got %b, required a queued expectation", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s[%0d]: conv/arm/go/done/fault got %b required %b at %0t",
                 e.name, e.idx, act, e.exp, $time);
      end
    end
    checks++;
    if (bus_if.dis_go === 1'b1 && (bus_if.dis_arm !== 1'b1 || bus_if.conv_on !== 1'b0)) begin
      errors++;
      $display("[TB] FAIL invariant: go=%b arm=%b conv=%b required arm=1 conv=0 at %0t",
               bus_if.dis_go, bus_if.dis_arm, bus_if.conv_on, $time);
    end
  endtask

  task automatic runVec(input vec_t r);
    applyStimulus(r);
    for (int c = 0; c < r.cycles; c++) begin
      pushExp(r.name, c, r.exp);
      tick();
      checkOutput();
    end
  endtask

  initial begin
    vec_t r;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;

    // Power-up: reset held 5 cycles, en_req already high.
    addVec("pu_reset",   1, 0, 0, 0, 100,  5, X_OFF);
    addVec("pu_wait",    1, 0, 0, 0, 100, 10, X_OFF);
    addVec("pu_on",      1, 0, 0, 0, 100,  1, X_ON);
    addVec("on_idle",    1, 0, 0, 0, 100,  5, X_ON);
    // Enable glitches shorter than DEB_CYC (5 and 7) do not shut down.
    addVec("glitch5_lo", 0, 0, 0, 0, 100,  5, X_ON);
    addVec("glitch5_hi", 1, 0, 0, 0, 100, 12, X_ON);
    addVec("glitch7_lo", 0, 0, 0, 0, 100,  7, X_ON);
    addVec("glitch7_hi", 1, 0, 0, 0, 100, 12, X_ON);
    addVec("clr_in_on",  1, 0, 0, 1, 100,  2, X_ON);
    addVec("on_settle",  1, 0, 0, 0, 100,  2, X_ON);
    // Normal shutdown with vout_low arriving 20 cycles into DISCH.
    addVec("shut_wait",  0, 0, 0, 0, 100, 10, X_ON);
    addVec("shut_arm",   0, 0, 0, 0, 100,  1, X_ARM);
    addVec("shut_disch", 0, 0, 0, 0, 100, 20, X_DIS);
    addVec("shut_vlow",  0, 0, 1, 0, 100,  3, X_DIS);
    addVec("shut_done",  0, 0, 1, 0, 100,  1, X_DONE);
    addVec("shut_off",   0, 0, 1, 0, 100,  4, X_OFF);
    addVec("reen_wait",  1, 0, 0, 0, 100, 10, X_OFF);
    addVec("reen_on",    1, 0, 0, 0, 100,  3, X_ON);
    // UVLO pulse: ARM 3 cycles after the edge; dis_time=0 faults after 1 DISCH cycle.
    addVec("uvlo_hi",    1, 1, 0, 0,   0,  2, X_ON);
    addVec("uvlo_arm",   1, 1, 0, 0,   0,  1, X_ARM);
    addVec("dt0_disch",  1, 0, 0, 0,   0,  1, X_DIS);
    addVec("dt0_fault",  1, 0, 0, 0,   0,  5, X_FLT);
    addVec("dt0_clr",    1, 0, 0, 1,   0,  1, X_OFF);
    addVec("dt0_reon",   1, 0, 0, 0,   0,  2, X_ON);
    // Timeout at dis_time=50: 51 DISCH cycles, uvlo toggled inside DISCH.
    addVec("to_wait",    0, 0, 0, 0,  50, 10, X_ON);
    addVec("to_arm",     0, 0, 0, 0,  50,  1, X_ARM);
    addVec("to_dis_a",   0, 0, 0, 0,  50, 10, X_DIS);
    addVec("to_dis_uv",  0, 1, 0, 0,  50,  5, X_DIS);
    addVec("to_dis_b",   0, 0, 0, 0,  50, 36, X_DIS);
    addVec("to_fault",   0, 0, 0, 0,  50,  3, X_FLT);
    addVec("flt_en_hi",  1, 0, 0, 0,  50, 12, X_FLT);
    addVec("flt_uvlo",   0, 1, 0, 0,  50,  4, X_FLT);
    addVec("flt_en_hi2", 1, 0, 0, 0,  50, 14, X_FLT);
    addVec("flt_clr",    1, 0, 0, 1,  50,  1, X_OFF);
    addVec("flt_reon",   1, 0, 0, 0,  50,  3, X_ON);
    // Enable returning during DISCH does not abort; OFF re-enters ON afterwards.
    addVec("ab_wait",    0, 0, 0, 0, 100, 10, X_ON);
    addVec("ab_arm",     0, 0, 0, 0, 100,  1, X_ARM);
    addVec("ab_dis_en",  1, 0, 0, 0, 100, 20, X_DIS);
    addVec("ab_vlow",    1, 0, 1, 0, 100,  3, X_DIS);
    addVec("ab_done",    1, 0, 1, 0, 100,  1, X_DONE);
    addVec("ab_off",     1, 0, 1, 0, 100,  1, X_OFF);
    addVec("ab_reon",    1, 0, 0, 0, 100,  3, X_ON);
    // Lead-in to the mid-discharge reset.
    addVec("rs_wait",    0, 0, 0, 0, 100, 10, X_ON);
    addVec("rs_arm",     0, 0, 0, 0, 100,  1, X_ARM);
    addVec("rs_dis",     0, 0, 0, 0, 100,  4, X_DIS);

    applyStimulus(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 1) rst_n = 1'b1;
      runVec(vecs[i]);
    end

    // Async reset mid-DISCH: outputs must drop before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    pushExp("rs_async", 0, X_OFF);
    checkOutput();
    addVec("rs_hold",    0, 0, 0, 0, 100,  2, X_OFF);
    addVec("rs_after",   0, 0, 0, 0, 100, 12, X_OFF);
    r = vecs[vecs.size() - 2];
    runVec(r);
    rst_n = 1'b1;
    r = vecs[vecs.size() - 1];
    runVec(r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepdown_discharge_seq.md
Name: stepdown_discharge_seq

Overview:
- Clocked sequencer that drives the two inputs of the step-down discharge NAND2 cell (dis_arm -> i0, dis_go -> i1).
- The NAND output is active-low, so the discharge FET is on only while both inputs are high.
- On converter disable or UVLO, the block arms, then discharges Vout until the output comparator reports low, or until a programmable timeout, which raises a fault.
- Sits between the enable/UVLO control logic and the discharge gate-drive cell. Powered from the same CELV/CELG/SUB domain.

Parameters:
- DEB_CYC, 8, consecutive synced cycles required before the debounced enable changes (1..15).
- DIS_W, 10, width of the discharge timeout counter and of dis_time.

Ports:
- CLK  input  1  block clock, rising edge.
- RSTN  input  1  asynchronous active-low reset; deassertion is synchronous to CLK.
- CELV  input  1  supply (connectivity only).
- CELG  input  1  ground (connectivity only).
- SUB  input  1  substrate (connectivity only).
- en_req  input  1  converter enable request, asynchronous.
- uvlo  input  1  undervoltage flag, asynchronous, active-high.
- vout_low  input  1  comparator output, high when Vout is below the discharge threshold; asynchronous.
- dis_time  input  DIS_W  discharge timeout in CLK cycles; static while in DISCH.
- fault_clr  input  1  synchronous pulse that clears FAULT.
- conv_on  output  1  converter run enable.
- dis_arm  output  1  to NAND i0.
- dis_go  output  1  to NAND i1.
- dis_done  output  1  one-cycle pulse on successful discharge.
- dis_fault  output  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0, state OFF, counter 0, synchronizers 0, en_db 0.
- Input synchronizers:
  - en_req, uvlo and vout_low each pass through a 2-flop synchronizer.
  - en_db follows synced en_req only after DEB_CYC consecutive cycles of disagreement; the run counter restarts on any agreement.
  - Latency from en_req edge to en_db edge is 2+DEB_CYC cycles.
  - uvlo is synchronized only, not debounced.
- OFF:
  - All outputs 0.
  - Moves to ON when en_db=1 and uvlo_s=0.
- ON:
  - conv_on=1.
  - Moves to ARM when en_db=0 or uvlo_s=1; uvlo takes priority with the same result.
- ARM:
  - Lasts exactly 1 cycle. conv_on=0, dis_arm=1, dis_go=0 (break-before-make: converter is off before the FET turns on).
  - Moves to DISCH.
- DISCH:
  - dis_arm=1, dis_go=1.
  - Counter clears on entry and increments each DISCH cycle.
  - vout_low qualifies when vout_low_s has been 1 on 2 consecutive DISCH cycles; this moves to DONE.
  - When counter==dis_time and vout_low is not qualified, move to FAULT.
  - If qualification and timeout occur in the same cycle, qualification wins.
  - dis_time=0 always produces FAULT after the first DISCH cycle.
- DONE:
  - 1 cycle, dis_done=1, dis_arm=0, dis_go=0.
  - Moves to OFF.
- FAULT:
  - dis_fault=1, dis_arm=0, dis_go=0, conv_on=0.
  - Stays in FAULT regardless of en_db or uvlo until fault_clr=1, then moves to OFF.
  - dis_fault clears in the same transition.
- Boundary cases:
  - en_db returning to 1 during ARM or DISCH does not abort; the sequence runs to DONE or FAULT, then OFF, and OFF re-enters ON next cycle if the conditions hold.
  - uvlo toggling during DISCH has no effect.
  - fault_clr outside FAULT is ignored.
- Reset mid-operation: RSTN low immediately forces dis_go=0, dis_arm=0 and conv_on=0, with no glitch path through combinational logic.
- All outputs are registered directly from flops.
- Invariant: dis_go=1 implies dis_arm=1 and conv_on=0, every cycle.

Test Plan:
- Power-up: RSTN low for 5 cycles, en_req=1 from time 0. After RSTN high, expect conv_on=1 exactly 2+8+1 cycles later; dis_* remain 0.
- Normal shutdown, dis_time=100: drop en_req; vout_low rises 20 cycles into DISCH.
  - Expect one ARM cycle with dis_arm=1, dis_go=0.
  - dis_go high until qualification.
  - dis_done pulses once; return to OFF.
- Timeout, dis_time=50, vout_low held 0: expect dis_go high for exactly 51 cycles, then dis_fault=1 sticky. en_req toggling is ignored until fault_clr, then OFF.
- Debounce: 5-cycle en_req glitch low while ON, with DEB_CYC=8. Expect no ARM; conv_on stays 1.
- UVLO: pulse uvlo for 3 cycles while ON. Expect ARM 3 cycles after the rising edge, with no debounce delay.
- Async reset during DISCH: assert RSTN mid-DISCH. Expect dis_go=0 the same instant; after release, state OFF and all outputs 0.
